// File: rtl/mem_arbiter_pkg.sv
// Shared pipeline definitions for the IFU/LSU memory arbiter: FSM encoding,
// requester IDs and bus widths.
package mem_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'b00,
    ST_WAIT_IFU = 2'b01,
    ST_WAIT_LSU = 2'b10
  } arb_state_t;

  typedef enum logic {
    REQ_IFU = 1'b0,
    REQ_LSU = 1'b1
  } req_id_t;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int MASK_W = 4;

  // Requester that owns the transaction in flight for a given WAIT state.
  function automatic req_id_t owner_of(input arb_state_t st);
    return (st == ST_WAIT_LSU) ? REQ_LSU : REQ_IFU;
  endfunction

endpackage

// File: rtl/mem_req_holder.sv
// Per-requester pending flag and holding registers. Presents the requester's
// current candidate (same-cycle pulse or held request) to the arbiter.
module mem_req_holder
  import mem_arbiter_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              req,
  input  logic              flush,
  input  logic              own_busy,
  input  logic              grant,
  input  logic              wen,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [MASK_W-1:0] wmask,
  output logic              pend,
  output logic              cand,
  output logic              c_wen,
  output logic [ADDR_W-1:0] c_addr,
  output logic [DATA_W-1:0] c_wdata,
  output logic [MASK_W-1:0] c_wmask
);

  logic              pend_q;
  logic              h_wen;
  logic [ADDR_W-1:0] h_addr;
  logic [DATA_W-1:0] h_wdata;
  logic [MASK_W-1:0] h_wmask;
  logic              accept;

  // A flush starts a new path, so a coincident pulse is accepted even if an
  // older request is still pending or in flight; otherwise a second request
  // is a protocol violation and is dropped.
  assign accept = req & (flush | (~pend_q & ~own_busy));
  assign cand   = accept | (pend_q & ~flush);
  assign pend   = pend_q;

  assign c_wen   = accept ? wen   : h_wen;
  assign c_addr  = accept ? addr  : h_addr;
  assign c_wdata = accept ? wdata : h_wdata;
  assign c_wmask = accept ? wmask : h_wmask;

  always_ff @(posedge clk) begin
    if (rst) begin
      pend_q  <= 1'b0;
      h_wen   <= 1'b0;
      h_addr  <= '0;
      h_wdata <= '0;
      h_wmask <= '0;
    end else if (grant) begin
      pend_q <= 1'b0;
    end else if (accept) begin
      pend_q  <= 1'b1;
      h_wen   <= wen;
      h_addr  <= addr;
      h_wdata <= wdata;
      h_wmask <= wmask;
    end else if (flush) begin
      pend_q <= 1'b0;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates IFU fetches and LSU accesses onto one memory port, one
// transaction in flight, with LSU priority bounded by an IFU starvation limit.
// Handshake: every req/rvalid/mem_req/mem_rvalid is a one-cycle pulse with its
// payload valid in the same cycle; there is no ready, acceptance is implicit.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ifu_req,
  input  logic [31:0] ifu_addr,
  output logic        ifu_rvalid,
  output logic [31:0] ifu_rdata,
  input  logic        lsu_req,
  input  logic        lsu_wen,
  input  logic [31:0] lsu_addr,
  input  logic [31:0] lsu_wdata,
  input  logic [3:0]  lsu_wmask,
  output logic        lsu_rvalid,
  output logic [31:0] lsu_rdata,
  output logic        mem_req,
  output logic        mem_wen,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wmask,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata,
  input  logic        flush,
  output logic        busy,
  output logic [1:0]  dbg_state
);

  localparam int SW = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;
  localparam logic [SW-1:0] LIMIT = SW'(STARVE_LIMIT);

  arb_state_t  state_q, state_d;
  logic [SW-1:0] streak_q;
  logic        drop_q;

  logic        in_wait, arb_en, resp_ok, starve_hit;
  logic        gnt_ifu, gnt_lsu;
  logic        ifu_pend, ifu_cand, ifu_c_wen;
  logic [31:0] ifu_c_addr, ifu_c_wdata;
  logic [3:0]  ifu_c_wmask;
  logic        lsu_pend, lsu_cand, lsu_c_wen;
  logic [31:0] lsu_c_addr, lsu_c_wdata;
  logic [3:0]  lsu_c_wmask;

  assign in_wait = (state_q != ST_IDLE);
  assign arb_en  = ~in_wait | mem_rvalid;

  // The IFU fetch never writes, so its holder is fed constant store fields.
  mem_req_holder u_ifu_hold (
    .clk      (clk),
    .rst      (rst),
    .req      (ifu_req),
    .flush    (flush),
    .own_busy ((state_q == ST_WAIT_IFU) & ~mem_rvalid),
    .grant    (gnt_ifu),
    .wen      (1'b0),
    .addr     (ifu_addr),
    .wdata    (32'd0),
    .wmask    (4'd0),
    .pend     (ifu_pend),
    .cand     (ifu_cand),
    .c_wen    (ifu_c_wen),
    .c_addr   (ifu_c_addr),
    .c_wdata  (ifu_c_wdata),
    .c_wmask  (ifu_c_wmask)
  );

  mem_req_holder u_lsu_hold (
    .clk      (clk),
    .rst      (rst),
    .req      (lsu_req),
    .flush    (flush),
    .own_busy ((state_q == ST_WAIT_LSU) & ~mem_rvalid),
    .grant    (gnt_lsu),
    .wen      (lsu_wen),
    .addr     (lsu_addr),
    .wdata    (lsu_wdata),
    .wmask    (lsu_wmask),
    .pend     (lsu_pend),
    .cand     (lsu_cand),
    .c_wen    (lsu_c_wen),
    .c_addr   (lsu_c_addr),
    .c_wdata  (lsu_c_wdata),
    .c_wmask  (lsu_c_wmask)
  );

  assign starve_hit = (STARVE_LIMIT != 0) && ifu_cand && (streak_q == LIMIT);
  assign gnt_lsu    = arb_en & lsu_cand & ~starve_hit;
  assign gnt_ifu    = arb_en & ifu_cand & ~gnt_lsu;

  always_comb begin
    state_d = state_q;
    if (arb_en) begin
      if (gnt_lsu)      state_d = ST_WAIT_LSU;
      else if (gnt_ifu) state_d = ST_WAIT_IFU;
      else              state_d = ST_IDLE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      streak_q <= '0;
    end else if (gnt_ifu || (gnt_lsu && !ifu_cand)) begin
      streak_q <= '0;
    end else if (gnt_lsu && streak_q != LIMIT) begin
      streak_q <= streak_q + SW'(1);
    end
  end

  // A response completing this cycle retires the old transaction; any flush
  // here only affects it, never the one granted in the same cycle.
  always_ff @(posedge clk) begin
    if (rst)                    drop_q <= 1'b0;
    else if (in_wait && mem_rvalid) drop_q <= 1'b0;
    else if (in_wait && flush)  drop_q <= 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mem_req   <= 1'b0;
      mem_wen   <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_wmask <= '0;
    end else begin
      mem_req <= gnt_lsu | gnt_ifu;
      if (gnt_lsu) begin
        mem_wen   <= lsu_c_wen;
        mem_addr  <= lsu_c_addr;
        mem_wdata <= lsu_c_wdata;
        mem_wmask <= lsu_c_wmask;
      end else if (gnt_ifu) begin
        mem_wen   <= ifu_c_wen;
        mem_addr  <= ifu_c_addr;
        mem_wdata <= ifu_c_wdata;
        mem_wmask <= ifu_c_wmask;
      end
    end
  end

  assign resp_ok    = in_wait & mem_rvalid & ~drop_q & ~flush;
  assign ifu_rvalid = resp_ok & (owner_of(state_q) == REQ_IFU);
  assign lsu_rvalid = resp_ok & (owner_of(state_q) == REQ_LSU);
  assign ifu_rdata  = ifu_rvalid ? mem_rdata : 32'd0;
  assign lsu_rdata  = lsu_rvalid ? mem_rdata : 32'd0;

  assign busy      = in_wait | ifu_pend | lsu_pend;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: inputs change on the falling edge, outputs
// are sampled 1ns later, memory responses are driven by hand per scenario.
module tb_mem_arbiter;
  import mem_arbiter_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        ifu_req;
  logic [31:0] ifu_addr;
  logic        ifu_rvalid;
  logic [31:0] ifu_rdata;
  logic        lsu_req, lsu_wen;
  logic [31:0] lsu_addr, lsu_wdata;
  logic [3:0]  lsu_wmask;
  logic        lsu_rvalid;
  logic [31:0] lsu_rdata;
  logic        mem_req, mem_wen;
  logic [31:0] mem_addr, mem_wdata;
  logic [3:0]  mem_wmask;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;
  logic        flush;
  logic        busy;
  logic [1:0]  dbg_state;

  int errors = 0;
  int checks = 0;

  logic [31:0] g_addr   [7] = '{32'h8000_0100, 32'h8000_0104, 32'h3000_0100, 32'h8000_0108,
                                32'h8000_010C, 32'h3000_0104, 32'h8000_0110};
  logic [31:0] resp_lsu [7] = '{32'h8000_0104, 32'h8000_0108, 32'h0, 32'h8000_010C,
                                32'h8000_0110, 32'h0, 32'h0};
  logic [31:0] resp_ifu [7] = '{32'h0, 32'h0, 32'h3000_0104, 32'h0, 32'h0, 32'h0, 32'h0};

  mem_arbiter #(.STARVE_LIMIT(2)) dut (
    .clk        (clk),
    .rst        (rst),
    .ifu_req    (ifu_req),
    .ifu_addr   (ifu_addr),
    .ifu_rvalid (ifu_rvalid),
    .ifu_rdata  (ifu_rdata),
    .lsu_req    (lsu_req),
    .lsu_wen    (lsu_wen),
    .lsu_addr   (lsu_addr),
    .lsu_wdata  (lsu_wdata),
    .lsu_wmask  (lsu_wmask),
    .lsu_rvalid (lsu_rvalid),
    .lsu_rdata  (lsu_rdata),
    .mem_req    (mem_req),
    .mem_wen    (mem_wen),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_wmask  (mem_wmask),
    .mem_rvalid (mem_rvalid),
    .mem_rdata  (mem_rdata),
    .flush      (flush),
    .busy       (busy),
    .dbg_state  (dbg_state)
  );

  // clock
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Move to the next falling edge and drop all one-cycle pulses.
  task automatic next_cyc();
    @(negedge clk);
    ifu_req    = 1'b0;
    lsu_req    = 1'b0;
    mem_rvalid = 1'b0;
    mem_rdata  = 32'd0;
    flush      = 1'b0;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic drive_ifu(input logic [31:0] a);
    ifu_req  = 1'b1;
    ifu_addr = a;
  endtask

  task automatic drive_lsu(input logic w, input logic [31:0] a, input logic [31:0] d,
                           input logic [3:0] m);
    lsu_req   = 1'b1;
    lsu_wen   = w;
    lsu_addr  = a;
    lsu_wdata = d;
    lsu_wmask = m;
  endtask

  task automatic respond(input logic [31:0] d);
    mem_rvalid = 1'b1;
    mem_rdata  = d;
  endtask

  initial begin
    logic is_lsu;
    rst = 1'b1;
    ifu_req = 0; ifu_addr = 0; lsu_req = 0; lsu_wen = 0; lsu_addr = 0;
    lsu_wdata = 0; lsu_wmask = 0; mem_rvalid = 0; mem_rdata = 0; flush = 0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    settle();

    // reset state
    check("rst_mem_req", 32'(mem_req), 32'd0);
    check("rst_mem_addr", mem_addr, 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_state", 32'(dbg_state), 32'(ST_IDLE));

    // mem_rvalid in IDLE is ignored
    next_cyc(); respond(32'hAAAA_5555); settle();
    check("idle_rv_ifu", 32'(ifu_rvalid), 32'd0);
    check("idle_rv_lsu", 32'(lsu_rvalid), 32'd0);
    next_cyc(); settle();
    check("idle_rv_no_req", 32'(mem_req), 32'd0);
    check("idle_rv_busy", 32'(busy), 32'd0);

    // single IFU fetch, 1-cycle grant latency
    next_cyc(); drive_ifu(32'h3000_0000); settle();
    check("fetch_req_early", 32'(mem_req), 32'd0);
    next_cyc(); settle();
    check("fetch_mem_req", 32'(mem_req), 32'd1);
    check("fetch_addr", mem_addr, 32'h3000_0000);
    check("fetch_wen", 32'(mem_wen), 32'd0);
    check("fetch_wmask", 32'(mem_wmask), 32'd0);
    check("fetch_state", 32'(dbg_state), 32'(ST_WAIT_IFU));
    check("fetch_busy", 32'(busy), 32'd1);
    next_cyc(); settle();
    check("fetch_req_pulse", 32'(mem_req), 32'd0);
    next_cyc(); respond(32'h0000_0413); settle();
    check("fetch_ifu_rvalid", 32'(ifu_rvalid), 32'd1);
    check("fetch_ifu_rdata", ifu_rdata, 32'h0000_0413);
    check("fetch_lsu_rvalid", 32'(lsu_rvalid), 32'd0);
    next_cyc(); settle();
    check("fetch_done_rv", 32'(ifu_rvalid), 32'd0);
    check("fetch_done_rdata", ifu_rdata, 32'd0);
    check("fetch_done_busy", 32'(busy), 32'd0);

    // simultaneous IFU fetch and LSU store: store first, fetch back-to-back
    next_cyc();
    drive_ifu(32'h3000_0004);
    drive_lsu(1'b1, 32'h8000_0004, 32'hDEAD_BEEF, 4'b1111);
    settle();
    next_cyc(); settle();
    check("both_st_req", 32'(mem_req), 32'd1);
    check("both_st_wen", 32'(mem_wen), 32'd1);
    check("both_st_addr", mem_addr, 32'h8000_0004);
    check("both_st_wdata", mem_wdata, 32'hDEAD_BEEF);
    check("both_st_wmask", 32'(mem_wmask), 32'hF);
    next_cyc(); respond(32'd0); settle();
    check("both_st_lsu_rv", 32'(lsu_rvalid), 32'd1);
    check("both_st_ifu_rv", 32'(ifu_rvalid), 32'd0);
    next_cyc(); settle();
    check("both_if_req", 32'(mem_req), 32'd1);
    check("both_if_addr", mem_addr, 32'h3000_0004);
    check("both_if_wen", 32'(mem_wen), 32'd0);
    check("both_if_wdata", mem_wdata, 32'd0);
    check("both_if_wmask", 32'(mem_wmask), 32'd0);
    next_cyc(); respond(32'h1234_5678); settle();
    check("both_if_ifu_rv", 32'(ifu_rvalid), 32'd1);
    check("both_if_rdata", ifu_rdata, 32'h1234_5678);
    check("both_if_lsu_rv", 32'(lsu_rvalid), 32'd0);
    next_cyc(); settle();
    check("both_done_busy", 32'(busy), 32'd0);

    // starvation limit 2: expected grant order L L I L L I L
    next_cyc();
    drive_ifu(32'h3000_0100);
    drive_lsu(1'b0, 32'h8000_0100, 32'd0, 4'd0);
    settle();
    for (int k = 0; k < 7; k++) begin
      next_cyc(); settle();
      check($sformatf("starve_req%0d", k), 32'(mem_req), 32'd1);
      check($sformatf("starve_addr%0d", k), mem_addr, g_addr[k]);
      next_cyc();
      respond(32'h0000_0100 + 32'(k));
      if (resp_lsu[k] != 32'd0) drive_lsu(1'b0, resp_lsu[k], 32'd0, 4'd0);
      if (resp_ifu[k] != 32'd0) drive_ifu(resp_ifu[k]);
      settle();
      is_lsu = g_addr[k][31];
      check($sformatf("starve_lsu_rv%0d", k), 32'(lsu_rvalid), 32'(is_lsu));
      check($sformatf("starve_ifu_rv%0d", k), 32'(ifu_rvalid), 32'(!is_lsu));
    end
    next_cyc(); settle();
    check("starve_done_req", 32'(mem_req), 32'd0);
    check("starve_done_busy", 32'(busy), 32'd0);

    // flush during WAIT_IFU with a new fetch in the flush cycle
    next_cyc(); drive_ifu(32'h3000_0000); settle();
    next_cyc(); settle();
    check("flush_first_req", 32'(mem_req), 32'd1);
    next_cyc(); flush = 1'b1; drive_ifu(32'h3000_0010); settle();
    next_cyc(); respond(32'h1111_1111); settle();
    check("flush_stale_rv", 32'(ifu_rvalid), 32'd0);
    check("flush_stale_rdata", ifu_rdata, 32'd0);
    next_cyc(); settle();
    check("flush_new_req", 32'(mem_req), 32'd1);
    check("flush_new_addr", mem_addr, 32'h3000_0010);
    next_cyc(); respond(32'h2222_2222); settle();
    check("flush_new_rv", 32'(ifu_rvalid), 32'd1);
    check("flush_new_rdata", ifu_rdata, 32'h2222_2222);
    next_cyc(); settle();
    check("flush_done_busy", 32'(busy), 32'd0);

    // flush coincident with mem_rvalid drops that response
    next_cyc(); drive_lsu(1'b0, 32'h8000_0020, 32'd0, 4'd0); settle();
    next_cyc(); settle();
    check("flushrv_req", 32'(mem_req), 32'd1);
    next_cyc(); respond(32'h3333_3333); flush = 1'b1; settle();
    check("flushrv_lsu_rv", 32'(lsu_rvalid), 32'd0);
    next_cyc(); settle();
    check("flushrv_busy", 32'(busy), 32'd0);

    // reset during WAIT_LSU, late response ignored
    next_cyc(); drive_lsu(1'b1, 32'h8000_0008, 32'hCAFE_F00D, 4'b0011); settle();
    next_cyc(); settle();
    check("rstmid_req", 32'(mem_req), 32'd1);
    check("rstmid_state", 32'(dbg_state), 32'(ST_WAIT_LSU));
    next_cyc(); rst = 1'b1; settle();
    next_cyc(); rst = 1'b0; settle();
    check("rstmid_mem_req", 32'(mem_req), 32'd0);
    check("rstmid_mem_wen", 32'(mem_wen), 32'd0);
    check("rstmid_mem_addr", mem_addr, 32'd0);
    check("rstmid_mem_wdata", mem_wdata, 32'd0);
    check("rstmid_mem_wmask", 32'(mem_wmask), 32'd0);
    check("rstmid_busy", 32'(busy), 32'd0);
    next_cyc(); respond(32'h4444_4444); settle();
    check("rstmid_lsu_rv", 32'(lsu_rvalid), 32'd0);
    check("rstmid_lsu_rdata", lsu_rdata, 32'd0);
    next_cyc(); settle();
    check("rstmid_after_req", 32'(mem_req), 32'd0);
    check("rstmid_after_busy", 32'(busy), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
